// File: rtl/program_sequencer.sv
// program_sequencer: program counter and instruction fetch stage.
// Drives the program RAM address, runs a 4-phase req/ack handshake with the RAM,
// and presents each fetched word to the decoder over valid/ready. On each accept
// the decoder may redirect the pc: a jump pushes the return address onto a small
// return stack, and a return pops it.
// Optional build macro SEQ_ACK_SYNC_EN: mem_ack goes through a 2-flop
// synchronizer before the FSM sees it. Leave it undefined only when mem_ack is
// synchronous to clk.
module program_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  jmp,
  input  logic [ADDR_WIDTH-1:0] jmp_target,
  input  logic                  rtn,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  stack_err
);

  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] S_DRAIN   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic                  push;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [IDXW-1:0]       top_idx;
  logic [IDXW-1:0]       push_idx;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  ack_s;

`ifdef SEQ_ACK_SYNC_EN
  logic ack_meta_q, ack_sync_q;

  // Two-flop synchronizer. Reset to "ack high" so DRAIN waits until the RAM's
  // real ack level has propagated through before allowing a new request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b1;
      ack_sync_q <= 1'b1;
    end else begin
      ack_meta_q <= mem_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  assign ack_s = ack_sync_q;
`else
  assign ack_s = mem_ack;
`endif

  assign pc_inc      = pc_q + 1'b1;
  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign top_idx     = IDXW'(sp_q - 1'b1);
  assign push_idx    = IDXW'(sp_q);

  // Fetch FSM, pc redirect and stack pointer next-state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    err_d   = err_q;
    sp_d    = sp_q;
    push    = 1'b0;
    case (state_q)
      S_DRAIN: begin
        req_d = 1'b0;
        if (!ack_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!halt) begin
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Data is captured on the first cycle ack is seen; the RAM holds it
        // until req drops, so it is stable here.
        if (ack_s) begin
          instr_d = mem_data;
          req_d   = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          vld_d   = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (instr_ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
          if (jmp) begin
            pc_d = jmp_target;
            if (stack_full) begin
              err_d = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + 1'b1;
            end
          end else if (rtn) begin
            if (stack_empty) begin
              pc_d  = '0;
              err_d = 1'b1;
            end else begin
              pc_d = stack_q[top_idx];
              sp_d = sp_q - 1'b1;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        vld_d   = 1'b0;
        state_d = S_DRAIN;
      end
    endcase
  end

  // Control and datapath registers; reset aborts any fetch via DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_DRAIN;
      pc_q    <= '0;
      req_q   <= 1'b0;
      instr_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      sp_q    <= sp_d;
    end
  end

  // Return-address storage; validity is tracked by sp_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= pc_inc;
  end

  assign mem_addr    = pc_q;
  assign mem_req     = req_q;
  assign instr       = instr_q;
  assign instr_valid = vld_q;
  assign pc          = pc_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a 4-phase RAM responder, a handshake/address
// stability monitor, a table of accept vectors and a few hand-written sequences.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halt = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       jmp = 1'b0;
  logic [7:0] jmp_target = 8'h00;
  logic       rtn = 1'b0;
  logic [7:0] pc;
  logic       stack_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [256];
  logic       ram_en = 1'b1;
  logic       mon_en = 1'b0;

  program_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jmp(jmp), .jmp_target(jmp_target), .rtn(rtn),
    .pc(pc), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // RAM responder: raises ack with data on a request, drops it after req falls.
  always @(negedge clk) begin
    if (ram_en) begin
      if (mem_req && !mem_ack) begin
        mem_ack  = 1'b1;
        mem_data = ram[mem_addr];
      end else if (!mem_req && mem_ack) begin
        mem_ack = 1'b0;
      end
    end
  end

  // Handshake monitor: no new request while ack is high, address stable in handshake.
  logic       p_req = 1'b0, p_ack = 1'b0;
  logic [7:0] p_addr = 8'h00;
  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n) begin
      if (!p_req && mem_req && mem_ack) begin
        errors++;
        $display("FAIL req_while_ack: mem_req rose with mem_ack=1 at addr %0h", mem_addr);
      end
      if ((p_req || p_ack) && (mem_req || mem_ack) && mem_addr != p_addr) begin
        errors++;
        $display("FAIL addr_stable: mem_addr %0h changed from %0h during handshake", mem_addr, p_addr);
      end
    end
    p_req  = mem_req;
    p_ack  = mem_ack;
    p_addr = mem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; waits (bounded) for instr_valid.
  task automatic wait_valid(input string name);
    for (int i = 0; i < 60; i++) begin
      if (instr_valid) break;
      @(posedge clk); #1;
    end
    chk({name, "_valid_timeout"}, instr_valid, 1'b1);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 60; i++) begin
      if (mem_req) break;
      @(posedge clk); #1;
    end
    chk({name, "_req_timeout"}, mem_req, 1'b1);
  endtask

  typedef struct {
    logic       j;
    logic       r;
    logic [7:0] tgt;
    logic [7:0] pc0;
    logic [7:0] pc1;
    logic       err;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  initial begin
    logic ok;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    ram[0] = 8'hA3;
    ram[1] = 8'h51;

    //            jmp  rtn  tgt    pc     next   err
    vt[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 8'h00, 8'h01, 8'h02, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 8'h02, 8'h03, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 8'h03, 8'h04, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 8'h04, 8'h05, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 8'h40, 8'h05, 8'h40, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 8'h00, 8'h40, 8'h06, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 8'h10, 8'h06, 8'h10, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 8'h20, 8'h10, 8'h20, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 8'h30, 8'h20, 8'h30, 1'b0};
    vt[10] = '{1'b1, 1'b1, 8'h50, 8'h30, 8'h50, 1'b0};
    vt[11] = '{1'b1, 1'b0, 8'h60, 8'h50, 8'h60, 1'b1};
    vt[12] = '{1'b0, 1'b1, 8'h00, 8'h60, 8'h31, 1'b1};
    vt[13] = '{1'b0, 1'b1, 8'h00, 8'h31, 8'h21, 1'b1};
    vt[14] = '{1'b0, 1'b1, 8'h00, 8'h21, 8'h11, 1'b1};
    vt[15] = '{1'b0, 1'b1, 8'h00, 8'h11, 8'h07, 1'b1};
    vt[16] = '{1'b0, 1'b1, 8'h00, 8'h07, 8'h00, 1'b1};
    vt[17] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b1};
    vt[18] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b1};
    vt[19] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1};

    // Reset state, held in reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_err", stack_err, 1'b0);

    rst_n = 1'b1;
    halt = 1'b0;
    mon_en = 1'b1;

    // Vector table: one accepted instruction per entry.
    for (int v = 0; v < NV; v++) begin
      wait_valid($sformatf("v%0d", v));
      chk($sformatf("v%0d_pc", v), pc, vt[v].pc0);
      chk($sformatf("v%0d_instr", v), instr, ram[vt[v].pc0]);
      jmp = vt[v].j;
      rtn = vt[v].r;
      jmp_target = vt[v].tgt;
      instr_ready = 1'b1;
      @(posedge clk); #1;
      instr_ready = 1'b0;
      jmp = 1'b0;
      rtn = 1'b0;
      chk($sformatf("v%0d_next_pc", v), pc, vt[v].pc1);
      chk($sformatf("v%0d_valid_clr", v), instr_valid, 1'b0);
      chk($sformatf("v%0d_err", v), stack_err, vt[v].err);
    end

    // jmp/rtn while not accepting: no effect.
    wait_valid("noacc");
    jmp = 1'b1;
    rtn = 1'b1;
    jmp_target = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    chk("noacc_pc", pc, 8'h01);
    chk("noacc_valid", instr_valid, 1'b1);
    jmp = 1'b0;
    rtn = 1'b0;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    chk("noacc_next_pc", pc, 8'h02);

    // halt raised while presenting: fetch completes, then no new request.
    wait_valid("halt");
    halt = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_req || instr_valid) ok = 1'b0;
    end
    chk("halt_no_req", ok, 1'b1);
    chk("halt_pc", pc, 8'h03);
    halt = 1'b0;
    wait_valid("resume");
    chk("resume_pc", pc, 8'h03);
    chk("resume_instr", instr, ram[3]);
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    ram_en = 1'b0;
    chk("resume_next_pc", pc, 8'h04);

    // Reset while in REQ with ack high: abort, then wait for ack to drop.
    wait_req("rstreq");
    mon_en = 1'b0;
    mem_ack = 1'b1;
    mem_data = 8'hEE;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstreq_req", mem_req, 1'b0);
    chk("rstreq_pc", pc, 8'h00);
    chk("rstreq_err", stack_err, 1'b0);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (mem_req || instr_valid) ok = 1'b0;
    end
    chk("rstreq_hold", ok, 1'b1);
    mem_ack = 1'b0;
    ram_en = 1'b1;
    mon_en = 1'b1;
    wait_valid("rstreq_fetch");
    chk("rstreq_fetch_pc", pc, 8'h00);
    chk("rstreq_fetch_instr", instr, 8'hA3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
